spi_host_data_fifo: RTL and testbench

SPI_HOST_DATA_FIFO -- requirements
Module: spi_host_data_fifo

---
 rtl/spi_host_data_fifo.sv | 105 ++++++++++
 tb/tb_spi_host_data_fifo.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_host_data_fifo.sv
// spi_host_data_fifo: synchronous FIFO for SPI host data.
// Entries are stored in a register array and read back with one cycle of
// latency. Any Depth of at least 2 works, including non-powers of two.
// Optional feature: define SPI_HOST_FIFO_WATERMARK_EN to build the registered
// watermark flag wm_o. Without it, wm_o is tied low.
//
// Handshake: a write is accepted on a rising edge where wvalid_i && wready_o.
// A read is consumed on a rising edge where rvalid_o && rready_i. While clr_i
// is high, neither side transfers: the flush wins over both.
module spi_host_data_fifo #(
  parameter int unsigned Width   = 8,
  parameter int unsigned Depth   = 8,
  parameter int unsigned WmLevel = 4,
  // Occupancy width; same value as prim_util_pkg::vbits(Depth+1).
  localparam int unsigned DepthW = ((Depth + 1) <= 1) ? 1 : $clog2(Depth + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  input  logic [Width-1:0]  wdata_i,
  output logic              rvalid_o,
  input  logic              rready_i,
  output logic [Width-1:0]  rdata_o,
  output logic              full_o,
  output logic [DepthW-1:0] depth_o,
  output logic              wm_o
);

  localparam int unsigned PtrW = (Depth <= 1) ? 1 : $clog2(Depth);
  localparam logic [PtrW-1:0]   PtrLast = PtrW'(Depth - 1);
  localparam logic [DepthW-1:0] DepthFull = DepthW'(Depth);

  logic [Width-1:0]  mem_q [Depth];
  logic [PtrW-1:0]   wptr_q, wptr_d;
  logic [PtrW-1:0]   rptr_q, rptr_d;
  logic [DepthW-1:0] depth_q, depth_d;
  logic              w_acc, r_acc;

  // Status and handshake outputs derived from the registered occupancy.
  assign full_o   = (depth_q == DepthFull);
  assign rvalid_o = (depth_q != '0);
  assign wready_o = ~full_o & ~clr_i;
  assign depth_o  = depth_q;
  assign rdata_o  = rvalid_o ? mem_q[rptr_q] : '0;

  // A read is ignored during a flush. A write already is, because wready_o is low.
  assign w_acc = wvalid_i & wready_o;
  assign r_acc = rvalid_o & rready_i & ~clr_i;

  // Next pointer and occupancy values. Each pointer wraps explicitly at Depth-1.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    depth_d = depth_q;
    if (clr_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      depth_d = '0;
    end else begin
      if (w_acc) wptr_d = (wptr_q == PtrLast) ? '0 : wptr_q + PtrW'(1);
      if (r_acc) rptr_d = (rptr_q == PtrLast) ? '0 : rptr_q + PtrW'(1);
      case ({w_acc, r_acc})
        2'b10:   depth_d = depth_q + DepthW'(1);
        2'b01:   depth_d = depth_q - DepthW'(1);
        default: depth_d = depth_q;
      endcase
    end
  end

  // Pointer and occupancy registers. Reset discards all stored entries.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      depth_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      depth_q <= depth_d;
    end
  end

  // Storage array. It has no reset, because the occupancy count decides what is valid.
  always_ff @(posedge clk_i) begin
    if (w_acc) mem_q[wptr_q] <= wdata_i;
  end

`ifdef SPI_HOST_FIFO_WATERMARK_EN
  logic wm_q, wm_d;
  assign wm_d = (depth_d >= DepthW'(WmLevel));

  // Watermark flag, registered in the same cycle as the occupancy it reflects.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) wm_q <= 1'b0;
    else       wm_q <= wm_d;
  end

  assign wm_o = wm_q;
`else
  assign wm_o = 1'b0;
`endif

endmodule

// File: tb/tb_spi_host_data_fifo.sv
// tb_spi_host_data_fifo: directed checks of spi_host_data_fifo.
// It uses one Depth=8 instance and one Depth=5 instance.
module tb_spi_host_data_fifo;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

`ifdef SPI_HOST_FIFO_WATERMARK_EN
  logic wm_on = 1'b1;
`else
  logic wm_on = 1'b0;
`endif

  // Depth=8 instance
  logic       clr = 0, wv = 0, rr = 0;
  logic [7:0] wd = '0;
  logic       wrdy, rv, full, wm;
  logic [7:0] rd;
  logic [3:0] dep;

  spi_host_data_fifo #(.Width(8), .Depth(8), .WmLevel(4)) dut8 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .wvalid_i(wv), .wready_o(wrdy),
    .wdata_i(wd), .rvalid_o(rv), .rready_i(rr), .rdata_o(rd), .full_o(full),
    .depth_o(dep), .wm_o(wm)
  );

  // Depth=5 instance (non-power-of-two wrap)
  logic       clr5 = 0, wv5 = 0, rr5 = 0;
  logic [7:0] wd5 = '0;
  logic       wrdy5, rv5, full5, wm5;
  logic [7:0] rd5;
  logic [2:0] dep5;

  spi_host_data_fifo #(.Width(8), .Depth(5), .WmLevel(2)) dut5 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr5), .wvalid_i(wv5), .wready_o(wrdy5),
    .wdata_i(wd5), .rvalid_o(rv5), .rready_i(rr5), .rdata_o(rd5), .full_o(full5),
    .depth_o(dep5), .wm_o(wm5)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  // Step past the next rising edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wv = 1'b1; wd = d;
    tick();
    wv = 1'b0;
    exp_q.push_back(d);
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    e = exp_q.pop_front();
    #1;
    check(tag, rd, e);
    rr = 1'b1;
    tick();
    rr = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    tick(); tick();
    check("rst_depth", dep, 0);
    check("rst_rvalid", rv, 0);
    check("rst_full", full, 0);
    check("rst_wm", wm, 0);
    check("rst_wready", wrdy, 1);
    check("rst_rdata", rd, 0);
    rst = 1'b0;
    tick();

    // The first write must be visible only after the edge.
    wv = 1'b1; wd = 8'hA5;
    #1;
    check("a5_rvalid_before", rv, 0);
    check("a5_rdata_before", rd, 0);
    tick();
    wv = 1'b0;
    check("a5_rvalid", rv, 1);
    check("a5_rdata", rd, 8'hA5);
    check("a5_depth", dep, 1);
    rr = 1'b1; tick(); rr = 1'b0;
    check("a5_drained_rvalid", rv, 0);
    check("a5_drained_rdata", rd, 0);

    // Fill to full, attempt a ninth write, then drain in order.
    for (int i = 0; i < 8; i++) begin
      push(8'(i));
      if (i == 2) check("wm_at3", wm, 0);
      if (i == 3) check("wm_at4", wm, wm_on);
    end
    check("fill_full", full, 1);
    check("fill_wready", wrdy, 0);
    check("fill_depth", dep, 8);
    wv = 1'b1; wd = 8'h99;
    tick();
    wv = 1'b0;
    check("ninth_depth", dep, 8);
    for (int i = 0; i < 8; i++) begin
      pop_check("fill_order");
      if (i == 3) check("wm_drain4", wm, wm_on);
      if (i == 4) check("wm_drain3", wm, 0);
    end
    check("fill_empty_rvalid", rv, 0);
    check("fill_empty_depth", dep, 0);

    // When full, a write in the same cycle as a read is refused.
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    wv = 1'b1; wd = 8'hEE; rr = 1'b1;
    #1;
    check("full_rw_wready", wrdy, 0);
    tick();
    void'(exp_q.pop_front());
    check("full_rw_depth", dep, 7);
    wv = 1'b1; wd = 8'hEF; rr = 1'b0;
    #1;
    check("freed_wready", wrdy, 1);
    tick();
    wv = 1'b0;
    exp_q.push_back(8'hEF);
    check("freed_depth", dep, 8);
    for (int i = 0; i < 8; i++) pop_check("full_rw_order");
    check("full_rw_empty", rv, 0);

    // A synchronous clear ignores a write in the same cycle.
    push(8'h30); push(8'h31); push(8'h32);
    check("clr_pre_depth", dep, 3);
    clr = 1'b1; wv = 1'b1; wd = 8'h55; rr = 1'b1;
    #1;
    check("clr_wready", wrdy, 0);
    tick();
    clr = 1'b0; wv = 1'b0; rr = 1'b0;
    exp_q.delete();
    check("clr_depth", dep, 0);
    check("clr_rvalid", rv, 0);
    check("clr_rdata", rd, 0);
    push(8'h66);
    check("post_clr_rdata", rd, 8'h66);

    // Reset in the middle of a burst clears without a clock edge.
    push(8'h67); push(8'h68);
    check("burst_depth", dep, 3);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_depth", dep, 0);
    check("async_rst_rvalid", rv, 0);
    check("async_rst_rdata", rd, 0);
    exp_q.delete();
    #1;
    rst = 1'b0;
    tick();
    check("post_rst_depth", dep, 0);
    push(8'h77);
    check("post_rst_rdata", rd, 8'h77);
    check("post_rst_depth1", dep, 1);

    // Depth=5: twelve write/read pairs at depth 2 wrap both pointers.
    wv5 = 1'b1; wd5 = 8'h80; tick();
    wd5 = 8'h81; tick();
    wv5 = 1'b0;
    check("d5_depth_init", dep5, 2);
    for (int i = 0; i < 12; i++) begin
      wv5 = 1'b1; wd5 = 8'h82 + 8'(i); rr5 = 1'b1;
      #1;
      check("d5_head", rd5, 8'h80 + 8'(i));
      tick();
      check("d5_depth", dep5, 2);
    end
    wv5 = 1'b0;
    #1;
    check("d5_tail0", rd5, 8'h8C);
    tick();
    check("d5_tail1", rd5, 8'h8D);
    tick();
    rr5 = 1'b0;
    check("d5_empty", rv5, 0);
    check("d5_full_never", full5, 0);
    check("d5_wm_idle", wm5, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog: keeps a stalled run from hanging.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
